// File: rtl/jk_cmd_pkg.sv
// ---------------------------------------------------------------------------
// jk_cmd_pkg
// Shared definitions for the JK flip-flop command sequencer.
//   CMD_*   : {j,k} command encodings accepted on the upstream interface
//   state_t : sequencer FSM states
//   CMD_W   : command width (one j bit, one k bit)
//   GAP_W   : width of the idle-gap counter (GAP range 0..15)
// ---------------------------------------------------------------------------
package jk_cmd_pkg;

    localparam int CMD_W = 2;
    localparam int GAP_W = 4;

    localparam logic [CMD_W-1:0] CMD_HOLD = 2'b00;
    localparam logic [CMD_W-1:0] CMD_CLR  = 2'b01;
    localparam logic [CMD_W-1:0] CMD_SET  = 2'b10;
    localparam logic [CMD_W-1:0] CMD_TOG  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// ---------------------------------------------------------------------------
// jk_cmd_fifo
// Small synchronous FIFO holding pending {j,k} commands.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (empties the FIFO)
//   i_push     write i_wdata this edge (ignored when full)
//   i_wdata    command to enqueue
//   i_pop      drop the head entry this edge (ignored when empty)
//   o_head     current head entry, valid whenever o_empty is low
//   o_full     occupancy == DEPTH
//   o_empty    occupancy == 0
//   o_count    occupancy, 0..DEPTH
// The head is read combinationally so the sequencer can load it into its
// output registers on the same edge that pops it.
// ---------------------------------------------------------------------------
module jk_cmd_fifo
    import jk_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [CMD_W-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [CMD_W-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == DEPTH_L);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage carries no reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer
// Buffers set/clear/toggle/hold requests and drives a JK flip-flop with one
// registered command per issue slot, followed by GAP idle (j=k=0) cycles.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   cmd_valid  upstream command present
//   cmd        {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   cmd_ready  FIFO can accept (transfer on cmd_valid && cmd_ready)
//   j, k       registered flip-flop inputs, non-zero only in issue cycles
//   issued     one-cycle pulse marking each issue cycle
//   busy       FSM not idle or commands still queued
//   count      FIFO occupancy
// ---------------------------------------------------------------------------
module jk_cmd_sequencer
    import jk_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    output logic                     j,
    output logic                     k,
    output logic                     issued,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam logic [GAP_W-1:0] GAP_L = GAP_W'(GAP);

    state_t           r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_j;
    logic             r_k;
    logic             r_issued;

    logic             w_push;
    logic             w_pop;
    logic [CMD_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [$clog2(DEPTH):0] w_count;

    // Ready comes only from registered occupancy: a pop in a full cycle does
    // not open a slot until the following cycle.
    assign cmd_ready = !reset && !w_full;
    assign w_push    = cmd_valid && cmd_ready;

    jk_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A new command may start only when the previous slot (issue cycle plus
    // its gap) is complete.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
            S_ISSUE: w_pop = (GAP == 0) && !w_empty;
            S_GAP:   w_pop = (r_gap_cnt <= GAP_W'(1)) && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_j       <= 1'b0;
            r_k       <= 1'b0;
            r_issued  <= 1'b0;
        end else begin
            // j/k are live for exactly one cycle per popped command.
            r_j      <= 1'b0;
            r_k      <= 1'b0;
            r_issued <= 1'b0;
            if (w_pop) begin
                r_j      <= w_head[1];
                r_k      <= w_head[0];
                r_issued <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (GAP != 0) begin
                        r_gap_cnt <= GAP_L;
                        r_state   <= S_GAP;
                    end else if (!w_pop) begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    // Counting <=1 rather than ==1 keeps a corrupted zero
                    // count from stalling the sequencer for 16 cycles.
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= w_pop ? S_ISSUE : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign j      = r_j;
    assign k      = r_k;
    assign issued = r_issued;
    assign count  = w_count;
    assign busy   = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Directed bench with three sequencer instances sharing clk/reset:
//   u_g1 : DEPTH=4, GAP=1
//   u_g3 : DEPTH=2, GAP=3
//   u_g0 : DEPTH=4, GAP=0
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point.
// ---------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

    localparam logic [1:0] C_HOLD = 2'b00;
    localparam logic [1:0] C_CLR  = 2'b01;
    localparam logic [1:0] C_SET  = 2'b10;
    localparam logic [1:0] C_TOG  = 2'b11;

    logic clk = 1'b0;
    logic reset;

    logic       v1, v3, v0;
    logic [1:0] c1, c3, c0;
    logic       r1, r3, r0;
    logic       j1, j3, j0;
    logic       k1, k3, k0;
    logic       i1, i3, i0;
    logic       b1, b3, b0;
    logic [2:0] n1, n0;
    logic [1:0] n3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(4), .GAP(1)) u_g1 (
        .clk(clk), .reset(reset), .cmd_valid(v1), .cmd(c1), .cmd_ready(r1),
        .j(j1), .k(k1), .issued(i1), .busy(b1), .count(n1)
    );

    jk_cmd_sequencer #(.DEPTH(2), .GAP(3)) u_g3 (
        .clk(clk), .reset(reset), .cmd_valid(v3), .cmd(c3), .cmd_ready(r3),
        .j(j3), .k(k3), .issued(i3), .busy(b3), .count(n3)
    );

    jk_cmd_sequencer #(.DEPTH(4), .GAP(0)) u_g0 (
        .clk(clk), .reset(reset), .cmd_valid(v0), .cmd(c0), .cmd_ready(r0),
        .j(j0), .k(k0), .issued(i0), .busy(b0), .count(n0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        v1 = 1'b1; c1 = C_SET;
        v3 = 1'b1; c3 = C_SET;
        v0 = 1'b1; c0 = C_SET;
        #1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            step();
            total++;
            if ({r1, r3, r0} !== 3'b000) begin
                bad++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=000", cyc, {r1, r3, r0});
            end
            total++;
            if ({j1, k1, i1, b1, n1} !== 7'd0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got j=%b k=%b iss=%b busy=%b cnt=%0d exp all 0",
                         cyc, j1, k1, i1, b1, n1);
            end
        end
        reset = 1'b0;
        v1 = 1'b0; v3 = 1'b0; v0 = 1'b0;
        #1;
        total++;
        if ({r1, r3, r0} !== 3'b111) begin
            bad++;
            $display("FAIL release_ready got=%b exp=111", {r1, r3, r0});
        end
        step();
        total++;
        if (n1 !== 3'd0 || n3 !== 2'd0 || n0 !== 3'd0 || b1 !== 1'b0) begin
            bad++;
            $display("FAIL release_empty got n1=%0d n3=%0d n0=%0d busy=%b exp 0", n1, n3, n0, b1);
        end
        $display("test_reset done");
    endtask

    // ---------------------------------------------------------------
    task automatic test_single();
        v1 = 1'b1; c1 = C_SET;
        step();                                   // edge t: accepted
        v1 = 1'b0;
        total++;
        if (n1 !== 3'd1 || i1 !== 1'b0 || j1 !== 1'b0) begin
            bad++;
            $display("FAIL single_accept got cnt=%0d iss=%b j=%b exp cnt=1 iss=0 j=0", n1, i1, j1);
        end
        step();                                   // edge t+1: issue
        total++;
        if ({j1, k1, i1} !== 3'b101) begin
            bad++;
            $display("FAIL single_issue got jk_iss=%b exp=101", {j1, k1, i1});
        end
        step();                                   // edge t+2: gap
        total++;
        if ({j1, k1, i1, b1} !== 4'b0001) begin
            bad++;
            $display("FAIL single_gap got jk_iss_busy=%b exp=0001", {j1, k1, i1, b1});
        end
        step();                                   // edge t+3: idle
        total++;
        if (b1 !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b exp=0", b1);
        end
        $display("test_single done");
    endtask

    // ---------------------------------------------------------------
    task automatic test_sequence();
        logic [1:0] cmds   [4] = '{C_SET, C_TOG, C_CLR, C_HOLD};
        logic [1:0] exp_jk [8] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic       exp_is [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int cyc = 0; cyc < 9; cyc++) begin
            v1 = (cyc < 4);
            c1 = (cyc < 4) ? cmds[cyc] : C_HOLD;
            step();
            if (cyc >= 1) begin
                total++;
                if ({j1, k1} !== exp_jk[cyc-1] || i1 !== exp_is[cyc-1]) begin
                    bad++;
                    $display("FAIL seq_jk cyc=%0d got jk=%b iss=%b exp jk=%b iss=%b",
                             cyc, {j1, k1}, i1, exp_jk[cyc-1], exp_is[cyc-1]);
                end
            end
        end
        step();
        total++;
        if (b1 !== 1'b0 || n1 !== 3'd0) begin
            bad++;
            $display("FAIL seq_end got busy=%b cnt=%0d exp busy=0 cnt=0", b1, n1);
        end
        $display("test_sequence done");
    endtask

    // ---------------------------------------------------------------
    task automatic test_backpressure();
        logic [1:0] cmds [4] = '{C_SET, C_CLR, C_TOG, C_HOLD};
        int idx       = 0;
        int n_iss     = 0;
        int last      = -1;
        bit saw_full  = 1'b0;
        bit saw_block = 1'b0;
        logic ready_now;
        for (int cyc = 0; cyc < 30; cyc++) begin
            v3 = (idx < 4);
            c3 = (idx < 4) ? cmds[idx] : C_HOLD;
            ready_now = r3;
            step();
            if (ready_now && idx < 4) idx++;
            if (n3 == 2'd2) saw_full = 1'b1;
            if (r3 == 1'b0 && idx < 4) saw_block = 1'b1;
            if (i3 === 1'b1) begin
                if (n_iss < 4) begin
                    total++;
                    if ({j3, k3} !== cmds[n_iss]) begin
                        bad++;
                        $display("FAIL bp_order n=%0d got jk=%b exp=%b", n_iss, {j3, k3}, cmds[n_iss]);
                    end
                end
                if (n_iss > 0) begin
                    total++;
                    if (cyc - last !== 4) begin
                        bad++;
                        $display("FAIL bp_spacing n=%0d got=%0d exp=4", n_iss, cyc - last);
                    end
                end
                last = cyc;
                n_iss++;
            end
        end
        v3 = 1'b0;
        total++;
        if (!saw_full || !saw_block) begin
            bad++;
            $display("FAIL bp_full got full_seen=%b ready_low_seen=%b exp 1 1", saw_full, saw_block);
        end
        total++;
        if (n_iss !== 4 || idx !== 4) begin
            bad++;
            $display("FAIL bp_count got issued=%0d accepted=%0d exp 4 4", n_iss, idx);
        end
        total++;
        if (b3 !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle got busy=%b exp=0", b3);
        end
        $display("test_backpressure done");
    endtask

    // ---------------------------------------------------------------
    task automatic test_back_to_back();
        logic [1:0] cmds   [3] = '{C_TOG, C_TOG, C_SET};
        logic [1:0] exp_jk [4] = '{2'b11, 2'b11, 2'b10, 2'b00};
        logic       exp_is [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int cyc = 0; cyc < 5; cyc++) begin
            v0 = (cyc < 3);
            c0 = (cyc < 3) ? cmds[cyc] : C_HOLD;
            step();
            if (cyc >= 1) begin
                total++;
                if ({j0, k0} !== exp_jk[cyc-1] || i0 !== exp_is[cyc-1]) begin
                    bad++;
                    $display("FAIL b2b_jk cyc=%0d got jk=%b iss=%b exp jk=%b iss=%b",
                             cyc, {j0, k0}, i0, exp_jk[cyc-1], exp_is[cyc-1]);
                end
            end
        end
        total++;
        if (b0 !== 1'b0 || n0 !== 3'd0) begin
            bad++;
            $display("FAIL b2b_idle got busy=%b cnt=%0d exp busy=0 cnt=0", b0, n0);
        end
        $display("test_back_to_back done");
    endtask

    // ---------------------------------------------------------------
    task automatic test_mid_reset();
        logic [1:0] cmds [4] = '{C_SET, C_TOG, C_CLR, C_HOLD};
        int pulses = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            v1 = 1'b1;
            c1 = cmds[cyc];
            step();
        end
        v1 = 1'b0;
        // Now in the TOG issue cycle with CLR and HOLD queued.
        total++;
        if ({j1, k1, i1} !== 3'b111 || n1 !== 3'd2) begin
            bad++;
            $display("FAIL mrst_pre got jk_iss=%b cnt=%0d exp jk_iss=111 cnt=2", {j1, k1, i1}, n1);
        end
        reset = 1'b1;
        #1;
        total++;
        if (r1 !== 1'b0) begin
            bad++;
            $display("FAIL mrst_ready got=%b exp=0", r1);
        end
        step();
        reset = 1'b0;
        total++;
        if ({j1, k1, i1, b1} !== 4'b0000 || n1 !== 3'd0) begin
            bad++;
            $display("FAIL mrst_clear got jk_iss_busy=%b cnt=%0d exp 0000 cnt=0", {j1, k1, i1, b1}, n1);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            if (i1 === 1'b1 || j1 === 1'b1 || k1 === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || b1 !== 1'b0) begin
            bad++;
            $display("FAIL mrst_quiet got stray_cycles=%0d busy=%b exp 0 0", pulses, b1);
        end
        $display("test_mid_reset done");
    endtask

    // ---------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound in case a wait ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream command stage for the team's synchronous JK flip-flop.
- Accepts set/clear/toggle/hold requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the flip-flop's j/k inputs with exactly one registered command per issue slot.
- Inserts a programmable number of idle (j=k=0) cycles between successive commands.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, >=2.
- GAP, 1: idle cycles (j=k=0) forced after each issued command; 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  upstream command present
- cmd  in  2  {j,k} command: 00 hold, 01 clear, 10 set, 11 toggle
- cmd_ready  out  1  FIFO can accept; transfer when cmd_valid && cmd_ready at rising edge
- j  out  1  registered j to flip-flop
- k  out  1  registered k to flip-flop
- issued  out  1  one-cycle pulse, coincident with the j/k issue cycle
- busy  out  1  state != IDLE or FIFO non-empty
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (sync, active-high): FIFO emptied, count=0, state=IDLE, j=k=0, issued=0, busy=0, gap counter=0.
  - cmd_ready=0 while reset is high; pushes during reset are ignored.
  - Reset asserted mid-operation discards all queued commands; outputs are zero the cycle after the reset edge.
- cmd_ready = !reset && (count < DEPTH), combinational from registered count.
  - When full, no pass-through: ready stays 0 even in a pop cycle.
- Push and pop in the same edge: count unchanged, write and read pointers both advance. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if count>0 at the edge, pop the head, j<=cmd[1], k<=cmd[0], issued<=1, go to ISSUE.
  - ISSUE (j/k valid for exactly this one cycle): at the next edge j<=0, k<=0, issued<=0.
    - GAP>0: load gap counter with GAP, go to GAP.
    - GAP==0 and count>0: pop the next command immediately, stay in ISSUE (back-to-back issue).
    - GAP==0 and FIFO empty: go to IDLE.
  - GAP: decrement the counter each edge. At the edge where the counter==1:
    - count>0: pop and go to ISSUE.
    - FIFO empty: go to IDLE.
- Latency: command accepted at edge t with the FIFO empty and state IDLE → j/k driven in the cycle after edge t+1. Same-cycle bypass is not allowed.
- Sustained input → issue pulses separated by exactly GAP zero cycles.
- Hold (00) occupies a full issue slot plus gap; issued still pulses.
- Commands are issued in arrival order. None are dropped or duplicated.
- j and k change only on clock edges (glitch-free to the flip-flop).

Decomposition:
- Package jk_cmd_pkg: CMD_HOLD=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_TOG=2'b11; state enum {IDLE, ISSUE, GAP}.
- Sub-module jk_cmd_fifo: synchronous FIFO (DEPTH, width 2), push/pop/full/empty/count, sync active-high reset.
- Top level holds the FSM, gap counter and output registers.

Test Plan:
1. Reset held 2 cycles, cmd_valid=1 → cmd_ready=0, j=k=0, count=0, busy=0 throughout. After release, cmd_ready=1 and nothing has been pushed.
2. GAP=1: single CMD_SET accepted at edge t → j=1,k=0,issued=1 for one cycle after edge t+1, then j=k=0. busy=0 after edge t+3.
3. GAP=1, DEPTH=4: push SET,TOG,CLR,HOLD on consecutive cycles → j/k sequence 10,00,11,00,01,00,00,00. issued pulses 4 times, 2 cycles apart.
4. GAP=3, DEPTH=2: cmd_valid held, 4 commands → count reaches 2 and cmd_ready drops to 0. Commands 3 and 4 are accepted only after pops. All 4 are issued in order, issue pulses 4 cycles apart.
5. GAP=0: push TOG,TOG,SET on consecutive cycles → j/k = 11,11,10 on consecutive cycles, then 00 and return to IDLE.
6. Reset asserted during ISSUE with 2 queued → next cycle j=k=0, count=0, state=IDLE. No further issued pulses after release without new pushes.
